// File: rtl/hangman_link_pkg.sv
// Shared definitions for the hangman host/player serial link:
// frame header, status byte layout and transmitter state encoding.
package hangman_link_pkg;

   localparam logic [7:0] HDR_DEFAULT = 8'h7E;

   localparam int ST_END     = 7;
   localparam int ST_HIT     = 6;
   localparam int ST_COR_MSB = 5;
   localparam int ST_COR_LSB = 3;
   localparam int ST_INC_MSB = 2;
   localparam int ST_INC_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   function automatic logic [7:0] pack_status(
      input logic       game_end,
      input logic       hit,
      input logic [2:0] correct,
      input logic [2:0] incorrect
   );
      logic [7:0] s;
      s                        = '0;
      s[ST_END]                = game_end;
      s[ST_HIT]                = hit;
      s[ST_COR_MSB:ST_COR_LSB] = correct;
      s[ST_INC_MSB:ST_INC_LSB] = incorrect;
      return s;
   endfunction

endpackage

// File: rtl/host_reply_tx_bit_tx.sv
// 8N1 serializer with a byte_valid/byte_ready handshake. A byte offered during
// the last stop-bit cycle is chained directly into the next start bit.
module reply_bit_tx
   import hangman_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       stop_last,
   output logic       busy,
   output logic       tx_serial
);

   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          baud_end;

   always_comb begin
      baud_end   = (baud_q == BAUD_LAST);
      stop_last  = (state_q == STOP) && baud_end;
      byte_ready = (state_q == IDLE) || stop_last;

      state_d    = state_q;
      baud_d     = baud_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;

      // tx_d always carries the line level of the state being entered, so the
      // serial output comes straight from a flop.
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (byte_valid) begin
               state_d = START;
               shift_d = byte_data;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_end) begin
               state_d   = DATA;
               baud_d    = '0;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[bit_idx_q + 3'd1];
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (byte_valid) begin
                  state_d = START;
                  shift_d = byte_data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign tx_serial = tx_q;

endmodule

// File: rtl/host_reply_tx.sv
// Host reply transmitter: captures each evaluated guess into a one-entry slot
// and sends it as a 4-byte 8N1 frame {HDR, letter, status, checksum}.
module host_reply_tx
   import hangman_link_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 1042,
   parameter logic [7:0] HDR          = HDR_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       status_valid,
   input  logic [7:0] letter,
   input  logic       hit,
   input  logic [2:0] correct,
   input  logic [2:0] incorrect,
   input  logic       game_end,
   output logic       status_ready,
   output logic       busy,
   output logic       tx_serial,
   output logic       frame_done,
   output logic       overrun
);

   logic            slot_full_q, slot_full_d;
   logic [7:0]      slot_letter_q, slot_letter_d;
   logic [7:0]      slot_status_q, slot_status_d;
   // b1..b3 of the frame in flight; b0 is always HDR and is fed directly.
   logic [2:0][7:0] frame_q, frame_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic            status_ready_q, status_ready_d;
   logic            overrun_q, overrun_d;
   logic            frame_done_q, frame_done_d;

   logic            ser_valid;
   logic [7:0]      ser_data;
   logic [7:0]      next_byte;
   logic            ser_ready;
   logic            ser_stop_last;
   logic            ser_busy;
   logic            load;
   logic            capture;

   always_comb begin
      case (byte_idx_q)
         2'd0:    next_byte = frame_q[0];
         2'd1:    next_byte = frame_q[1];
         default: next_byte = frame_q[2];
      endcase

      // While a frame runs, only its remaining bytes are offered; a queued
      // slot is offered only once the serializer is back in IDLE.
      ser_valid = ser_busy ? (byte_idx_q != 2'd3) : slot_full_q;
      ser_data  = ser_busy ? next_byte : HDR;
      load      = !ser_busy && slot_full_q && ser_ready;
      capture   = status_valid && status_ready_q;

      slot_full_d   = slot_full_q;
      slot_letter_d = slot_letter_q;
      slot_status_d = slot_status_q;
      frame_d       = frame_q;
      byte_idx_d    = byte_idx_q;
      overrun_d     = overrun_q | (status_valid & ~status_ready_q);

      if (load) begin
         slot_full_d = 1'b0;
         frame_d     = {HDR ^ slot_letter_q ^ slot_status_q, slot_status_q, slot_letter_q};
         byte_idx_d  = 2'd0;
      end else if (ser_valid && ser_ready) begin
         byte_idx_d = byte_idx_q + 2'd1;
      end

      if (capture) begin
         slot_full_d   = 1'b1;
         slot_letter_d = letter;
         slot_status_d = pack_status(game_end, hit, correct, incorrect);
      end

      status_ready_d = ~slot_full_d;
      frame_done_d   = ser_stop_last && (byte_idx_q == 2'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full_q    <= 1'b0;
         slot_letter_q  <= '0;
         slot_status_q  <= '0;
         frame_q        <= '0;
         byte_idx_q     <= '0;
         status_ready_q <= 1'b1;
         overrun_q      <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         slot_full_q    <= slot_full_d;
         slot_letter_q  <= slot_letter_d;
         slot_status_q  <= slot_status_d;
         frame_q        <= frame_d;
         byte_idx_q     <= byte_idx_d;
         status_ready_q <= status_ready_d;
         overrun_q      <= overrun_d;
         frame_done_q   <= frame_done_d;
      end
   end

   reply_bit_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_tx (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(ser_valid),
      .byte_data (ser_data),
      .byte_ready(ser_ready),
      .stop_last (ser_stop_last),
      .busy      (ser_busy),
      .tx_serial (tx_serial)
   );

   assign status_ready = status_ready_q;
   assign busy         = ser_busy;
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;

endmodule
